// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch synchroniser and debouncer; event/irq logic under SW_DEBOUNCE_IRQ_EN
module sw_debounce #(
  parameter int Width          = 16,
  parameter int DebounceCycles = 150_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] sw_ni,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] edge_o
`ifdef SW_DEBOUNCE_IRQ_EN
  ,
  input  logic [Width-1:0] irq_en_i,
  input  logic [Width-1:0] irq_clr_i,
  output logic [Width-1:0] event_o,
  output logic             irq_o
`endif
);

  localparam int CNT_W = $clog2(DebounceCycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DebounceCycles - 1);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;
  logic [Width-1:0] pressed;
  logic [Width-1:0] toggle;
  logic [Width-1:0] disagree;
  logic [Width-1:0] sw_d_q;
  logic [CNT_W-1:0] cnt_q [Width];

  // Synchroniser idles at 1 so a released (high) pin is the reset state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_ni;
      sync2_q <= sync1_q;
    end
  end

  assign pressed  = ~sync2_q;
  assign disagree = pressed ^ sw_o;

  always_comb begin
    toggle = '0;
    for (int i = 0; i < Width; i++) begin
      toggle[i] = disagree[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Counter clears whenever input agrees, so any short glitch restarts the window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Width; i++) begin
        if (!disagree[i] || toggle[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_o   <= '0;
      sw_d_q <= '0;
      edge_o <= '0;
    end else begin
      sw_o   <= sw_o ^ toggle;
      sw_d_q <= sw_o;
      edge_o <= sw_o ^ sw_d_q;
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  // Set wins over clear so an edge coinciding with a clear is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_o <= '0;
      irq_o   <= 1'b0;
    end else begin
      event_o <= (event_o & ~irq_clr_i) | edge_o;
      irq_o   <= |(event_o & irq_en_i);
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed bench for sw_debounce (DebounceCycles 4 and 1)
module tb_sw_debounce;

  logic        clk;
  logic        rst_i;
  logic [15:0] sw_ni;
  logic [15:0] sw_o;
  logic [15:0] edge_o;
  logic [1:0]  sw_ni1;
  logic [1:0]  sw_o1;
  logic [1:0]  edge_o1;
`ifdef SW_DEBOUNCE_IRQ_EN
  logic [15:0] irq_en_i;
  logic [15:0] irq_clr_i;
  logic [15:0] event_o;
  logic        irq_o;
  logic [1:0]  irq_en1;
  logic [1:0]  irq_clr1;
  logic [1:0]  event_o1;
  logic        irq_o1;
`endif

  int errors = 0;
  int checks = 0;

  sw_debounce #(.Width(16), .DebounceCycles(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .sw_ni     (sw_ni),
    .sw_o      (sw_o),
    .edge_o    (edge_o)
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    .irq_en_i  (irq_en_i),
    .irq_clr_i (irq_clr_i),
    .event_o   (event_o),
    .irq_o     (irq_o)
`endif
  );

  sw_debounce #(.Width(2), .DebounceCycles(1)) dut1 (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .sw_ni     (sw_ni1),
    .sw_o      (sw_o1),
    .edge_o    (edge_o1)
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    .irq_en_i  (irq_en1),
    .irq_clr_i (irq_clr1),
    .event_o   (event_o1),
    .irq_o     (irq_o1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_i  = 1'b1;
    sw_ni  = 16'hFFFF;
    sw_ni1 = 2'b11;
`ifdef SW_DEBOUNCE_IRQ_EN
    irq_en_i  = 16'h0000;
    irq_clr_i = 16'h0000;
    irq_en1   = 2'b00;
    irq_clr1  = 2'b00;
`endif
    cyc(2);
    check("rst_sw", sw_o, 16'h0000);
    check("rst_edge", edge_o, 16'h0000);
    check("rst_sw1", {14'h0, sw_o1}, 16'h0000);
    rst_i = 1'b0;
    cyc(3);
    check("release_edge", edge_o, 16'h0000);
    check("release_sw", sw_o, 16'h0000);

    // Clean press of bit 3: sw_o at edge 6, edge_o at edge 7.
    sw_ni[3] = 1'b0;
    cyc(5);
    check("p3_c5_sw", sw_o, 16'h0000);
    cyc(1);
    check("p3_c6_sw", sw_o, 16'h0008);
    check("p3_c6_edge", edge_o, 16'h0000);
    cyc(1);
    check("p3_c7_edge", edge_o, 16'h0008);
    check("p3_c7_sw", sw_o, 16'h0008);
    cyc(1);
    check("p3_c8_edge", edge_o, 16'h0000);
    sw_ni[3] = 1'b1;
    cyc(5);
    check("r3_c5_sw", sw_o, 16'h0008);
    cyc(1);
    check("r3_c6_sw", sw_o, 16'h0000);
    cyc(1);
    check("r3_c7_edge", edge_o, 16'h0008);
    cyc(1);
    check("r3_c8_edge", edge_o, 16'h0000);

    // Glitch train on bit 0: 3 low, 1 high, five times.
    for (int r = 0; r < 5; r++) begin
      sw_ni[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        check("glitch_sw", sw_o, 16'h0000);
        check("glitch_edge", edge_o, 16'h0000);
      end
      sw_ni[0] = 1'b1;
      cyc(1);
      check("glitch_sw", sw_o, 16'h0000);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("glitch_tail_sw", sw_o, 16'h0000);
      check("glitch_tail_edge", edge_o, 16'h0000);
    end

    // Reset mid-debounce on bit 2 discards the partial count.
    sw_ni[2] = 1'b0;
    cyc(4);
    check("mid_sw", sw_o, 16'h0000);
    rst_i = 1'b1;
    #1;
    check("in_rst_sw", sw_o, 16'h0000);
    cyc(1);
    check("in_rst_sw2", sw_o, 16'h0000);
    check("in_rst_edge", edge_o, 16'h0000);
    rst_i = 1'b0;
    cyc(5);
    check("post_rst_c5_sw", sw_o, 16'h0000);
    check("post_rst_c5_edge", edge_o, 16'h0000);
    cyc(1);
    check("post_rst_c6_sw", sw_o, 16'h0004);
    cyc(1);
    check("post_rst_c7_edge", edge_o, 16'h0004);
    sw_ni[2] = 1'b1;
    cyc(8);
    check("post_rst_released", sw_o, 16'h0000);

    // DebounceCycles = 1: accepted after one synced cycle.
    sw_ni1[0] = 1'b0;
    cyc(2);
    check("d1_c2_sw", {14'h0, sw_o1}, 16'h0000);
    cyc(1);
    check("d1_c3_sw", {14'h0, sw_o1}, 16'h0001);
    cyc(1);
    check("d1_c4_edge", {14'h0, edge_o1}, 16'h0001);
    sw_ni1[0] = 1'b1;
    cyc(3);
    check("d1_rel_sw", {14'h0, sw_o1}, 16'h0000);
    cyc(1);
    check("d1_rel_edge", {14'h0, edge_o1}, 16'h0001);

`ifdef SW_DEBOUNCE_IRQ_EN
    cyc(2);
    irq_clr_i = 16'hFFFF;
    cyc(1);
    irq_clr_i = 16'h0000;
    cyc(1);
    check("irq_pre_event", event_o, 16'h0000);
    irq_en_i = 16'h0001;
    sw_ni[0] = 1'b0;
    cyc(8);
    check("irq_event_set", event_o, 16'h0001);
    check("irq_not_yet", {15'h0, irq_o}, 16'h0000);
    cyc(1);
    check("irq_asserted", {15'h0, irq_o}, 16'h0001);
    sw_ni[0] = 1'b1;
    cyc(7);
    check("irq_rel_edge", edge_o, 16'h0001);
    irq_clr_i = 16'h0001;
    cyc(1);
    irq_clr_i = 16'h0000;
    check("irq_set_wins", event_o, 16'h0001);
    irq_clr_i = 16'h0001;
    cyc(1);
    irq_clr_i = 16'h0000;
    check("irq_cleared", event_o, 16'h0000);
    cyc(1);
    check("irq_dropped", {15'h0, irq_o}, 16'h0000);

    irq_en_i = 16'h0000;
    sw_ni[1]  = 1'b0;
    sw_ni[15] = 1'b0;
    cyc(8);
    check("multi_event", event_o, 16'h8002);
    cyc(1);
    check("multi_no_irq", {15'h0, irq_o}, 16'h0000);
    irq_clr_i = 16'hFFFF;
    cyc(1);
    irq_clr_i = 16'h0000;
    check("multi_cleared", event_o, 16'h0000);
    check("multi_irq_low", {15'h0, irq_o}, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter Width, default 16, meaning number of switch inputs (5 joystick + 8 user + 3 selection).
REQ-002 Parameter DebounceCycles, default 150_000, meaning consecutive stable cycles required to accept a change (5 ms at 30 MHz); legal range 1..2^24-1.
REQ-003 Port clk_i  input  1  system clock; one clock domain only.
REQ-004 Port rst_i  input  1  reset, asynchronous assert, active-high.
REQ-005 Port sw_ni  input  Width  raw board switch pins, active-low, asynchronous to clk_i.
REQ-006 Port sw_o  output  Width  debounced switch state, active-high (1 = pressed); feeds the system GPIO input word.
REQ-007 Port edge_o  output  Width  one-cycle pulse per bit when sw_o[i] changes.
REQ-008 Port irq_en_i  input  Width  per-bit interrupt enable (present only with SW_DEBOUNCE_IRQ_EN).
REQ-009 Port irq_clr_i  input  Width  per-bit event clear strobe (present only with SW_DEBOUNCE_IRQ_EN).
REQ-010 Port event_o  output  Width  sticky change events (present only with SW_DEBOUNCE_IRQ_EN).
REQ-011 Port irq_o  output  1  level interrupt (present only with SW_DEBOUNCE_IRQ_EN).

Function
REQ-012 Each bit SHALL pass through a two-flop synchroniser, then be inverted to active-high before debouncing.
REQ-013 Each bit SHALL own a counter of $clog2(DebounceCycles+1) bits; the counter increments while synced bit != sw_o bit, and clears to 0 in any cycle they are equal.
REQ-014 When a counter would reach DebounceCycles, sw_o[i] SHALL toggle in that cycle's register update and the counter SHALL clear to 0 at the same edge.
REQ-015 Latency: a clean pin transition held steady SHALL appear on sw_o exactly 2 + DebounceCycles clock cycles later.
REQ-016 Any glitch shorter than DebounceCycles synced cycles SHALL leave sw_o unchanged and restart counting from 0.
REQ-017 edge_o[i] SHALL be high for exactly the one cycle following the cycle in which sw_o[i] changed; bits are fully independent.
REQ-018 With DebounceCycles = 1, a change SHALL be accepted after one synced cycle of disagreement.
REQ-019 Counters SHALL never wrap; by construction they never exceed DebounceCycles-1.

Reset
REQ-020 While rst_i is high: synchroniser flops = 1 (released), sw_o = 0, edge_o = 0, counters = 0, event_o = 0, irq_o = 0.
REQ-021 rst_i assertion mid-debounce SHALL discard the partial count; after release a held-pressed switch SHALL appear on sw_o after 2 + DebounceCycles cycles.
REQ-022 No edge_o pulse or event SHALL be generated by reset release itself.

Configuration
REQ-023 Macro SW_DEBOUNCE_IRQ_EN: when defined, event/interrupt logic is compiled in; when undefined, irq_en_i, irq_clr_i, event_o, irq_o and their flops are absent, and sw_o/edge_o behaviour is unchanged.
REQ-024 With the macro: event_o[i] SHALL set on edge_o[i], clear on irq_clr_i[i]; simultaneous set and clear SHALL leave it set.
REQ-025 With the macro: irq_o SHALL be registered |(event_o & irq_en_i), asserting one cycle after the event bit sets.

Verification
REQ-026 DebounceCycles=4; drive sw_ni[3] 1->0 and hold -> sw_o[3] rises at cycle 6, edge_o[3] pulses at cycle 7, other bits stay 0.
REQ-027 DebounceCycles=4; pulse sw_ni[0] low for 3 cycles, repeated 5 times with 1-cycle highs -> sw_o[0] stays 0, edge_o stays 0.
REQ-028 DebounceCycles=4; press bit 2, assert rst_i at count 2 for 1 cycle, keep pressed -> sw_o all 0 during reset, sw_o[2] = 1 at 6 cycles after release.
REQ-029 Macro defined, irq_en_i=16'h0001; press bit 0 -> event_o=16'h0001, irq_o=1 next cycle; pulse irq_clr_i=16'h0001 in the same cycle as a new edge on bit 0 -> event_o stays 16'h0001.
REQ-030 Macro defined, irq_en_i=0; press bits 1 and 15 together -> event_o=16'h8002, irq_o stays 0; irq_clr_i=16'hFFFF -> event_o=0.
